// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment animation controller.
// Holds the button bit positions, the debouncer state encoding and the
// default frame-period settings (all in clk cycles).
package seg7_pkg;

  // Bit positions inside the 4-bit raw button bus
  localparam int BTN_NEXT = 0;
  localparam int BTN_PREV = 1;
  localparam int BTN_FAST = 2;
  localparam int BTN_SLOW = 3;
  localparam int NUM_BTN  = 4;

  // Frame period defaults, in clk cycles
  localparam int P_DEFAULT_VAL = 10_000_000;
  localparam int P_STEP_VAL    = 1_000_000;
  localparam int P_MIN_VAL     = 1_000_000;
  localparam int P_MAX_VAL     = 20_000_000;

  // Debounce stable-high length default
  localparam int DEB_CYCLES_VAL = 512;

  // Debouncer states: waiting for a press, timing a press, press accepted
  typedef enum logic [1:0] {
    DEB_IDLE  = 2'd0,
    DEB_COUNT = 2'd1,
    DEB_HELD  = 2'd2
  } deb_state_e;

endpackage

// File: rtl/seg7_debounce.sv
// Single-button debouncer. A press is accepted once the input has been high
// for DEB_CYCLES consecutive clock cycles; acceptance produces exactly one
// registered single-cycle event_o. Nothing more is emitted until the input
// drops low, so holding a button never auto-repeats. Any low sample returns
// the FSM to IDLE with the count cleared. btn_i is expected to be already
// synchronous to clk.
module seg7_debounce
  import seg7_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_VAL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_i,
  output logic       event_o,
  output logic [1:0] state_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  // Count value seen on the cycle that carries the final required high sample
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  deb_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          event_q;

  // Debounce FSM with registered event output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DEB_IDLE;
      cnt_q   <= '0;
      event_q <= 1'b0;
    end else begin
      event_q <= 1'b0;
      if (!btn_i) begin
        state_q <= DEB_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          DEB_IDLE: begin
            if (DEB_CYCLES <= 1) begin
              state_q <= DEB_HELD;
              event_q <= 1'b1;
            end else begin
              state_q <= DEB_COUNT;
              cnt_q   <= CW'(1);
            end
          end
          DEB_COUNT: begin
            if (cnt_q >= CNT_LAST) begin
              state_q <= DEB_HELD;
              cnt_q   <= '0;
              event_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          DEB_HELD: begin
            state_q <= DEB_HELD;
          end
          default: begin
            state_q <= DEB_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign event_o = event_q;
  assign state_o = state_q;

endmodule

// File: rtl/seg7_anim_ctrl.sv
// Seven-segment animation controller. Four debounced buttons select the
// animation (next/prev, wrapping) and adjust the frame period (faster/slower,
// saturating). A tick counter advances frame_o once per period, wrapping at
// frame_last_i supplied by the external frame lookup.
//
// Optional build macro SEG7_AUTOCYCLE_EN: when defined, a frame wrap while
// auto_i is high advances to the next animation. A manual next/prev event in
// the same cycle wins. Without the macro auto_i is ignored.
//
// Handshake note: there is no valid/ready traffic here; debouncer events are
// single-cycle strobes consumed unconditionally on the following clock edge.
module seg7_anim_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_ANI    = 12,
  parameter int FRAME_W    = 5,
  parameter int CNT_W      = 25,
  parameter int P_DEFAULT  = P_DEFAULT_VAL,
  parameter int P_STEP     = P_STEP_VAL,
  parameter int P_MIN      = P_MIN_VAL,
  parameter int P_MAX      = P_MAX_VAL,
  parameter int DEB_CYCLES = DEB_CYCLES_VAL
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 btn_i,
  input  logic [FRAME_W-1:0]         frame_last_i,
  input  logic                       auto_i,
  output logic [$clog2(NUM_ANI)-1:0] ani_o,
  output logic [FRAME_W-1:0]         frame_o,
  output logic                       tick_o,
  output logic [CNT_W-1:0]           period_o
);

  localparam int ANI_W = $clog2(NUM_ANI);
  localparam logic [ANI_W-1:0] ANI_LAST = ANI_W'(NUM_ANI - 1);

  // Period arithmetic is done one bit wider than the period so that the
  // step add/subtract can be range-checked without wrapping.
  localparam logic [CNT_W:0]   STEP_X  = (CNT_W + 1)'(P_STEP);
  localparam logic [CNT_W:0]   MIN_X   = (CNT_W + 1)'(P_MIN);
  localparam logic [CNT_W:0]   MAX_X   = (CNT_W + 1)'(P_MAX);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(P_MIN);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(P_MAX);
  localparam logic [CNT_W-1:0] DEF_C   = CNT_W'(P_DEFAULT);

  // Debounced single-cycle button events
  logic [NUM_BTN-1:0] ev;
  logic [1:0]         deb_state [NUM_BTN];

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_deb
    seg7_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn_i[b]),
      .event_o(ev[b]),
      .state_o(deb_state[b])
    );
  end

  // Debouncer states are observation points only; auto_i is unused in the
  // default build. Fold them into a sink so they remain visible but idle.
  logic unused_sink;
  assign unused_sink = ^{auto_i, deb_state[0], deb_state[1], deb_state[2], deb_state[3]};

  logic [ANI_W-1:0]   ani_q,    ani_d;
  logic [FRAME_W-1:0] frame_q,  frame_d;
  logic               tick_q,   tick_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;

  logic             next_ev;
  logic             prev_ev;
  logic             manual_ev;
  logic             auto_adv;
  logic             ani_change;
  logic             tick_due;
  logic             frame_wrap;
  logic [CNT_W:0]   period_x;
  logic [CNT_W:0]   period_sum;

  // Next-state logic for animation, frame, tick counter and period
  always_comb begin
    ani_d      = ani_q;
    frame_d    = frame_q;
    tick_d     = 1'b0;
    period_d   = period_q;
    cnt_d      = cnt_q + CNT_W'(1);
    auto_adv   = 1'b0;

    next_ev    = ev[BTN_NEXT] & ~ev[BTN_PREV];
    prev_ev    = ev[BTN_PREV] & ~ev[BTN_NEXT];
    manual_ev  = ev[BTN_NEXT] | ev[BTN_PREV];

    // Compare against the period in force this cycle; a period just reduced
    // below the running count therefore ticks immediately.
    tick_due   = (cnt_q >= (period_q - CNT_W'(1)));
    frame_wrap = tick_due & (frame_q >= frame_last_i);

`ifdef SEG7_AUTOCYCLE_EN
    auto_adv   = frame_wrap & auto_i & ~manual_ev;
`endif

    ani_change = next_ev | prev_ev | auto_adv;

    if (next_ev || auto_adv) begin
      ani_d = (ani_q == ANI_LAST) ? '0 : ani_q + ANI_W'(1);
    end else if (prev_ev) begin
      ani_d = (ani_q == '0) ? ANI_LAST : ani_q - ANI_W'(1);
    end

    // A new animation restarts from frame 0 with a fresh period, no tick
    if (ani_change) begin
      frame_d = '0;
      cnt_d   = '0;
    end else if (tick_due) begin
      cnt_d   = '0;
      tick_d  = 1'b1;
      frame_d = frame_wrap ? '0 : frame_q + FRAME_W'(1);
    end

    period_x   = {1'b0, period_q};
    period_sum = period_x + STEP_X;
    if (ev[BTN_FAST] && !ev[BTN_SLOW]) begin
      period_d = (period_x < (MIN_X + STEP_X)) ? MIN_C : CNT_W'(period_x - STEP_X);
    end else if (ev[BTN_SLOW] && !ev[BTN_FAST]) begin
      period_d = (period_sum > MAX_X) ? MAX_C : period_sum[CNT_W-1:0];
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ani_q    <= '0;
      frame_q  <= '0;
      tick_q   <= 1'b0;
      period_q <= DEF_C;
      cnt_q    <= '0;
    end else begin
      ani_q    <= ani_d;
      frame_q  <= frame_d;
      tick_q   <= tick_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ani_o    = ani_q;
  assign frame_o  = frame_q;
  assign tick_o   = tick_q;
  assign period_o = period_q;

endmodule

// File: tb/tb_seg7_anim_ctrl.sv
// Self-checking bench for seg7_anim_ctrl. A behavioural reference model,
// expressed as run lengths of held buttons and elapsed cycles since the last
// frame advance, predicts every output each cycle; directed scenarios add
// fixed-value checks for saturation, wrap, debounce and reset behaviour.
module tb_seg7_anim_ctrl;

  localparam int NUM_ANI = 12;
  localparam int FRAME_W = 5;
  localparam int CNT_W   = 25;
  localparam int P_DEF   = 8;
  localparam int P_STEP  = 1_000_000;
  localparam int P_MIN   = 1_000_000;
  localparam int P_MAX   = 20_000_000;
  localparam int DEB     = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]         btn   = 4'h0;
  logic [FRAME_W-1:0] flast = 5'd3;
  logic               auto_req = 1'b0;

  logic [3:0]         ani_o;
  logic [FRAME_W-1:0] frame_o;
  logic               tick_o;
  logic [CNT_W-1:0]   period_o;

  seg7_anim_ctrl #(
    .NUM_ANI(NUM_ANI), .FRAME_W(FRAME_W), .CNT_W(CNT_W),
    .P_DEFAULT(P_DEF), .P_STEP(P_STEP), .P_MIN(P_MIN), .P_MAX(P_MAX),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_i       (btn),
    .frame_last_i(flast),
    .auto_i      (auto_req),
    .ani_o       (ani_o),
    .frame_o     (frame_o),
    .tick_o      (tick_o),
    .period_o    (period_o)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     m_run [4] = '{0, 0, 0, 0};
  bit     m_pend [4] = '{0, 0, 0, 0};
  int     m_ani = 0;
  int     m_frame = 0;
  int     m_elapsed = 0;
  bit     m_tick = 0;
  longint m_period = P_DEF;

  always @(posedge clk) begin : model
    bit ev [4];
    bit tick_due;
    bit wrap;
    int delta;
    if (reset) begin
      foreach (m_run[b]) begin
        m_run[b]  = 0;
        m_pend[b] = 0;
      end
      m_ani = 0; m_frame = 0; m_elapsed = 0; m_tick = 0; m_period = P_DEF;
    end else begin
      // events accepted last cycle act now
      ev = m_pend;
      for (int b = 0; b < 4; b++) begin
        if (btn[b]) begin
          m_run[b]++;
          m_pend[b] = (m_run[b] == DEB);
        end else begin
          m_run[b]  = 0;
          m_pend[b] = 0;
        end
      end
      tick_due = (m_elapsed + 1 >= m_period);
      wrap     = tick_due && (m_frame >= int'(flast));
      delta = 0;
      if (ev[0] && !ev[1]) delta = 1;
      else if (ev[1] && !ev[0]) delta = -1;
`ifdef SEG7_AUTOCYCLE_EN
      if (!ev[0] && !ev[1] && wrap && auto_req) delta = 1;
`endif
      if (delta != 0) begin
        m_ani = (m_ani + delta + NUM_ANI) % NUM_ANI;
        m_frame = 0; m_elapsed = 0; m_tick = 0;
      end else if (tick_due) begin
        m_elapsed = 0; m_tick = 1;
        m_frame = wrap ? 0 : m_frame + 1;
      end else begin
        m_elapsed++; m_tick = 0;
      end
      if (ev[2] && !ev[3]) m_period = (m_period - P_STEP < P_MIN) ? P_MIN : m_period - P_STEP;
      if (ev[3] && !ev[2]) m_period = (m_period + P_STEP > P_MAX) ? P_MAX : m_period + P_STEP;
    end
    #1;
    check_eq("m_ani",    32'(ani_o),    32'(m_ani));
    check_eq("m_frame",  32'(frame_o),  32'(m_frame));
    check_eq("m_tick",   32'(tick_o),   32'(m_tick));
    check_eq("m_period", 32'(period_o), 32'(m_period));
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    btn = mask;
    repeat (hold) @(negedge clk);
    btn = 4'h0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int exp_frames [5] = '{1, 2, 3, 0, 1};

  initial begin
    int nt, last_cyc, changes, waited;
    logic [3:0] prev_ani;
    logic [3:0] mask;

    repeat (3) @(negedge clk);
    check_eq("rst_ani",    32'(ani_o),    0);
    check_eq("rst_frame",  32'(frame_o),  0);
    check_eq("rst_tick",   32'(tick_o),   0);
    check_eq("rst_period", 32'(period_o), P_DEF);
    reset = 1'b0;

    // frame ticks every P_DEF cycles, frame sequence wraps after 3
    nt = 0; last_cyc = 0;
    for (int cyc = 1; cyc <= 60 && nt < 5; cyc++) begin
      @(negedge clk);
      if (tick_o) begin
        check_eq("tick_frame", 32'(frame_o), 32'(exp_frames[nt]));
        if (nt > 0) check_eq("tick_gap", 32'(cyc - last_cyc), P_DEF);
        last_cyc = cyc;
        nt++;
      end
    end
    check_eq("tick_count", 32'(nt), 5);

    // long hold gives exactly one next event
    do_reset();
    changes = 0; prev_ani = 4'd0;
    btn = 4'b0001;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ani_o !== prev_ani) changes++;
      prev_ani = ani_o;
    end
    btn = 4'h0;
    repeat (4) @(negedge clk);
    check_eq("hold_changes", 32'(changes), 1);
    check_eq("hold_ani", 32'(ani_o), 1);

    // short prev pulse is rejected
    press(4'b0010, 300);
    check_eq("short_prev", 32'(ani_o), 1);

    // prev from 0 wraps to the last animation and clears the frame
    do_reset();
    btn = 4'b0010;
    waited = 0;
    while (ani_o == 4'd0 && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    check_eq("prev_wrap_ani", 32'(ani_o), NUM_ANI - 1);
    check_eq("prev_wrap_frame", 32'(frame_o), 0);
    check_eq("prev_wrap_tick", 32'(tick_o), 0);
    btn = 4'h0;
    repeat (4) @(negedge clk);

    // frame wrap with auto-cycle request at the last animation
    flast = 5'd0; auto_req = 1'b1;
    waited = 0;
    while (!tick_o && ani_o == 4'(NUM_ANI - 1) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
`ifdef SEG7_AUTOCYCLE_EN
    check_eq("auto_ani", 32'(ani_o), 0);
`else
    check_eq("auto_ani", 32'(ani_o), NUM_ANI - 1);
    check_eq("auto_tick", 32'(tick_o), 1);
`endif
    auto_req = 1'b0; flast = 5'd3;
    repeat (3) @(negedge clk);

    // simultaneous opposing events cancel
    do_reset();
    press(4'b0001, DEB + 2);
    check_eq("next_ani", 32'(ani_o), 1);
    press(4'b0011, DEB + 2);
    check_eq("both_ani", 32'(ani_o), 1);
    press(4'b1000, DEB + 2);
    check_eq("slow_once", 32'(period_o), P_DEF + P_STEP);
    press(4'b1100, DEB + 2);
    check_eq("both_period", 32'(period_o), P_DEF + P_STEP);

    // reset mid-count takes effect immediately
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_ani",    32'(ani_o),    0);
    check_eq("mid_rst_frame",  32'(frame_o),  0);
    check_eq("mid_rst_tick",   32'(tick_o),   0);
    check_eq("mid_rst_period", 32'(period_o), P_DEF);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset during a press discards the accumulated hold time
    btn = 4'b0001;
    repeat (300) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("rst_press_none", 32'(ani_o), 0);
    repeat (250) @(negedge clk);
    check_eq("rst_press_event", 32'(ani_o), 1);
    btn = 4'h0;
    repeat (4) @(negedge clk);

    // period saturation both ways
    do_reset();
    for (int i = 0; i < 20; i++) press(4'b1000, DEB + 2);
    check_eq("period_max", 32'(period_o), P_MAX);
    for (int i = 0; i < 25; i++) press(4'b0100, DEB + 2);
    check_eq("period_min", 32'(period_o), P_MIN);

    // randomized traffic against the model
    do_reset();
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      flast    = 5'($urandom_range(0, 7));
      auto_req = 1'($urandom_range(0, 1));
      mask     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) mask = mask & 4'b0011;
      press(mask, $urandom_range(1, 600));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_anim_ctrl.md
SEG7_ANIM_CTRL -- requirements
Module: seg7_anim_ctrl

Interface
REQ-001 SHALL have parameter NUM_ANI, default 12: number of animations; animation index runs 0..NUM_ANI-1.
REQ-002 SHALL have parameter FRAME_W, default 5: frame index width.
REQ-003 SHALL have parameter CNT_W, default 25: tick counter and period width.
REQ-004 SHALL have parameters P_DEFAULT 10_000_000, P_STEP 1_000_000, P_MIN 1_000_000, P_MAX 20_000_000: frame period in clk cycles.
REQ-005 SHALL have parameter DEB_CYCLES, default 512: debounce stable-high length in cycles.
REQ-006 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port btn_i  input  4  raw buttons: [0] next animation, [1] previous animation, [2] faster, [3] slower.
REQ-009 SHALL have port frame_last_i  input  FRAME_W  last frame index of the current animation, from the external lookup.
REQ-010 SHALL have port auto_i  input  1  auto-cycle request.
REQ-011 SHALL have port ani_o  output  clog2(NUM_ANI)  current animation index.
REQ-012 SHALL have port frame_o  output  FRAME_W  current frame index.
REQ-013 SHALL have port tick_o  output  1  one-cycle pulse on each frame advance.
REQ-014 SHALL have port period_o  output  CNT_W  current frame period.

Function
REQ-015 Each button SHALL pass through a debouncer FSM with states IDLE -> COUNT (input high) -> HELD (input high for DEB_CYCLES consecutive cycles); a low input in any state returns it to IDLE with the count cleared.
REQ-016 A debouncer SHALL emit exactly one single-cycle event on the COUNT->HELD transition and nothing further until the input returns low; holding a button never repeats.
REQ-017 A next event SHALL set ani_o to ani_o+1, wrapping NUM_ANI-1 -> 0; a prev event SHALL set it to ani_o-1, wrapping 0 -> NUM_ANI-1.
REQ-018 Simultaneous next and prev events SHALL leave ani_o unchanged; simultaneous faster and slower events SHALL leave period_o unchanged.
REQ-019 Any change of ani_o SHALL clear frame_o and the tick counter in the same cycle and suppress tick_o in that cycle.
REQ-020 A faster event SHALL set period_o to max(period_o-P_STEP, P_MIN); a slower event SHALL set it to min(period_o+P_STEP, P_MAX); arithmetic SHALL use CNT_W+1 bits, with no wrap.
REQ-021 The tick counter SHALL count 0..period_o-1; when counter >= period_o-1 it SHALL reset to 0 and assert tick_o for one cycle, so a period reduction below the current count ticks on the next cycle.
REQ-022 On tick_o, frame_o SHALL increment; if frame_o >= frame_last_i it SHALL wrap to 0 instead.
REQ-023 Button events SHALL take effect on the clock edge after the debounce event; outputs SHALL be registered.

Reset
REQ-024 While reset is high: ani_o=0, frame_o=0, tick_o=0, period_o=P_DEFAULT, tick counter 0, all debouncers IDLE with counts 0.
REQ-025 Reset asserted mid-press SHALL discard the press; after release of reset, a still-held button SHALL need a full DEB_CYCLES before an event.

Configuration
REQ-026 With SEG7_AUTOCYCLE_EN defined, a frame wrap (REQ-022) while auto_i=1 SHALL advance ani_o as a next event, with REQ-019 applying; a manual next or prev event in the same cycle SHALL take priority.
REQ-027 Without SEG7_AUTOCYCLE_EN, auto_i SHALL be ignored and the port SHALL remain present.

Structure
REQ-028 Package seg7_pkg SHALL hold the button index constants (BTN_NEXT, BTN_PREV, BTN_FAST, BTN_SLOW), the debouncer state typedef, and the P_* defaults.
REQ-029 The debouncer SHALL be sub-module seg7_debounce, instantiated once per button.

Verification
REQ-030 Hold btn_i[0] for 600 cycles with DEB_CYCLES=512 -> exactly one event; ani_o goes 0->1; no further change while held.
REQ-031 Pulse btn_i[1] high for 300 cycles -> no event; then a valid prev press from ani_o=0 -> ani_o=11, frame_o=0.
REQ-032 Give 20 slower presses from reset -> period_o saturates at 20_000_000; give 25 faster presses -> period_o saturates at 1_000_000.
REQ-033 Set P_DEFAULT=8 and frame_last_i=3 -> tick_o every 8 cycles; frame_o sequence 0,1,2,3,0.
REQ-034 Complete next and prev presses on the same cycle -> ani_o unchanged; assert reset mid-count -> all outputs at reset values.
REQ-035 With SEG7_AUTOCYCLE_EN defined and auto_i=1, frame wrap at ani_o=11 -> ani_o=0; without the macro -> ani_o stays 11.
